// File: rtl/mul_share_pkg.sv
// Shared types for the multiplier-sharing arbiter: opcode, FSM states and the held request.
package mul_share_pkg;

    // Encoding mirrors cv32e40p_pkg::mul_opcode_e so the multiplier can be attached directly.
    typedef enum logic [2:0] {
        MUL_MAC32 = 3'b000,
        MUL_MSU32 = 3'b001,
        MUL_I     = 3'b010,
        MUL_IR    = 3'b011,
        MUL_DOT8  = 3'b100,
        MUL_DOT16 = 3'b101,
        MUL_H     = 3'b110
    } mul_opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } mul_share_state_e;

    typedef struct packed {
        mul_opcode_e opcode;
        logic [1:0]  short_signed;
        logic [31:0] operand_a;
        logic [31:0] operand_b;
        logic [31:0] operand_c;
    } mul_share_req_t;

    function automatic int rr_wrap(input int base, input int offset, input int n);
        return (base + offset) % n;
    endfunction

endpackage

// File: rtl/mul_share_if.sv
// Request/response channels between the requesters (master) and the arbiter (slave).
interface mul_share_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]                        req_valid_i;
    logic [NUM_REQ-1:0]                        req_ready_o;
    mul_share_pkg::mul_opcode_e [NUM_REQ-1:0]  req_operator_i;
    logic [NUM_REQ-1:0][1:0]                   req_short_signed_i;
    logic [NUM_REQ-1:0][31:0]                  req_operand_a_i;
    logic [NUM_REQ-1:0][31:0]                  req_operand_b_i;
    logic [NUM_REQ-1:0][31:0]                  req_operand_c_i;
    logic [NUM_REQ-1:0]                        rsp_valid_o;
    logic [NUM_REQ-1:0]                        rsp_ready_i;
    logic [31:0]                               rsp_result_o;
    logic                                      rsp_err_o;

    modport slave (
        input  req_valid_i, req_operator_i, req_short_signed_i,
               req_operand_a_i, req_operand_b_i, req_operand_c_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_result_o, rsp_err_o
    );

    modport master (
        output req_valid_i, req_operator_i, req_short_signed_i,
               req_operand_a_i, req_operand_b_i, req_operand_c_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_result_o, rsp_err_o
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: searches upward from last_i+1 with wrap-around.
module rr_arbiter
    import mul_share_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   gnt_idx_o,
    output logic               any_o
);

    always_comb begin
        logic [IDX_W-1:0] cand;
        gnt_o     = '0;
        gnt_idx_o = '0;
        any_o     = 1'b0;
        cand      = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = IDX_W'(rr_wrap(int'(last_i), off, NUM_REQ));
            if (!any_o && req_i[cand]) begin
                any_o       = 1'b1;
                gnt_o[cand] = 1'b1;
                gnt_idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/mul_share_arbiter.sv
// Shares one multiplier between NUM_REQ requesters with round-robin grant and a BUSY watchdog.
//   state   | meaning
//   ST_IDLE | waiting for a request; grants one winner per cycle
//   ST_BUSY | multiplier enabled with held operands until ready or watchdog
//   ST_RESP | result presented to the owner until it accepts
module mul_share_arbiter
    import mul_share_pkg::*;
#(
    parameter  int NUM_REQ         = 2,
    parameter  int MAX_BUSY_CYCLES = 8,
    localparam int IDX_W           = $clog2(NUM_REQ),
    localparam int CNT_W           = $clog2(MAX_BUSY_CYCLES)
) (
    input  logic              clk,
    input  logic              rst,
    mul_share_if.slave        bus,
    output logic              mul_enable_o,
    output mul_opcode_e       mul_operator_o,
    output logic [1:0]        mul_short_signed_o,
    output logic [31:0]       mul_operand_a_o,
    output logic [31:0]       mul_operand_b_o,
    output logic [31:0]       mul_operand_c_o,
    output logic              mul_ex_ready_o,
    input  logic [31:0]       mul_result_i,
    input  logic              mul_ready_i,
    output logic              busy_o,
    output logic [IDX_W-1:0]  grant_id_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BUSY_CYCLES - 1);

    mul_share_state_e   state_q, state_d;
    mul_share_req_t     hold_q, hold_d;
    logic [IDX_W-1:0]   grant_q, grant_d, last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        res_q, res_d;
    logic               err_q, err_d, flush_q, flush_d;
    logic [NUM_REQ-1:0] win_oh, req_ready, rsp_valid;
    logic [IDX_W-1:0]   win_idx;
    logic               win_any;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req_i     (bus.req_valid_i),
        .last_i    (last_q),
        .gnt_o     (win_oh),
        .gnt_idx_o (win_idx),
        .any_o     (win_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            grant_q <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            cnt_q   <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            err_q   <= err_d;
            flush_q <= flush_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        hold_d         = hold_q;
        grant_d        = grant_q;
        last_d         = last_q;
        cnt_d          = cnt_q;
        res_d          = res_q;
        err_d          = err_q;
        flush_d        = 1'b0;
        req_ready      = '0;
        rsp_valid      = '0;
        mul_enable_o   = 1'b0;
        // The watchdog flush lands in the first RESP cycle to reset the multiplier's MULH sequencer.
        mul_ex_ready_o = flush_q;
        unique case (state_q)
            ST_IDLE: begin
                if (win_any) begin
                    req_ready           = win_oh;
                    hold_d.opcode       = bus.req_operator_i[win_idx];
                    hold_d.short_signed = bus.req_short_signed_i[win_idx];
                    hold_d.operand_a    = bus.req_operand_a_i[win_idx];
                    hold_d.operand_b    = bus.req_operand_b_i[win_idx];
                    hold_d.operand_c    = bus.req_operand_c_i[win_idx];
                    grant_d             = win_idx;
                    last_d              = win_idx;
                    cnt_d               = '0;
                    state_d             = ST_BUSY;
                end
            end
            ST_BUSY: begin
                mul_enable_o   = 1'b1;
                mul_ex_ready_o = mul_ready_i;
                if (mul_ready_i) begin
                    res_d   = mul_result_i;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    flush_d = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                rsp_valid[grant_q] = 1'b1;
                if (bus.rsp_ready_i[grant_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Synchronous reset still drops strobes combinationally so nothing is handed out mid-reset.
        if (rst) begin
            req_ready      = '0;
            rsp_valid      = '0;
            mul_enable_o   = 1'b0;
            mul_ex_ready_o = 1'b0;
        end
    end

    assign bus.req_ready_o    = req_ready;
    assign bus.rsp_valid_o    = rsp_valid;
    assign bus.rsp_result_o   = res_q;
    assign bus.rsp_err_o      = err_q && (state_q == ST_RESP);
    assign mul_operator_o     = hold_q.opcode;
    assign mul_short_signed_o = hold_q.short_signed;
    assign mul_operand_a_o    = hold_q.operand_a;
    assign mul_operand_b_o    = hold_q.operand_b;
    assign mul_operand_c_o    = hold_q.operand_c;
    assign busy_o             = (state_q != ST_IDLE);
    assign grant_id_o         = grant_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter with a small behavioural multiplier on the mul_* side.
module tb_mul_share_arbiter;
    import mul_share_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        mul_enable, mul_ex_ready, mul_ready, busy, stall;
    mul_opcode_e mul_operator;
    logic [1:0]  mul_short_signed;
    logic [31:0] mul_operand_a, mul_operand_b, mul_operand_c, mul_result;
    logic [0:0]  grant_id;
    int          checks = 0;
    int          errors = 0;
    int          mulh_cnt = 0;
    int          exr_cnt = 0;
    int          exr_base;
    logic signed [65:0] prod;

    mul_share_if #(.NUM_REQ(2)) bus ();

    mul_share_arbiter #(.NUM_REQ(2), .MAX_BUSY_CYCLES(8)) dut (
        .clk                (clk),
        .rst                (rst),
        .bus                (bus),
        .mul_enable_o       (mul_enable),
        .mul_operator_o     (mul_operator),
        .mul_short_signed_o (mul_short_signed),
        .mul_operand_a_o    (mul_operand_a),
        .mul_operand_b_o    (mul_operand_b),
        .mul_operand_c_o    (mul_operand_c),
        .mul_ex_ready_o     (mul_ex_ready),
        .mul_result_i       (mul_result),
        .mul_ready_i        (mul_ready),
        .busy_o             (busy),
        .grant_id_o         (grant_id)
    );

    always #5 clk = ~clk;

    // MULH needs four enabled cycles; everything else completes in one.
    always @(posedge clk) begin
        if (mul_enable && mul_operator == MUL_H && !mul_ex_ready) mulh_cnt <= mulh_cnt + 1;
        else mulh_cnt <= 0;
        if (mul_ex_ready) exr_cnt <= exr_cnt + 1;
    end

    assign mul_ready = !stall && !(mul_enable && mul_operator == MUL_H && mulh_cnt < 3);

    always_comb begin
        prod = $signed({mul_short_signed[0] & mul_operand_a[31], mul_operand_a}) *
               $signed({mul_short_signed[1] & mul_operand_b[31], mul_operand_b});
        if (mul_operator == MUL_H) mul_result = prod[63:32];
        else mul_result = mul_operand_a * mul_operand_b + mul_operand_c;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic set_req(input int r, input mul_opcode_e op, input logic [1:0] ss,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        bus.req_operator_i[r]     = op;
        bus.req_short_signed_i[r] = ss;
        bus.req_operand_a_i[r]    = a;
        bus.req_operand_b_i[r]    = b;
        bus.req_operand_c_i[r]    = c;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        stall = 1'b0;
        bus.req_valid_i = '0;
        bus.rsp_ready_i = '0;
        set_req(0, MUL_MAC32, 2'b00, '0, '0, '0);
        set_req(1, MUL_MAC32, 2'b00, '0, '0, '0);
        nxt(); nxt();
        rst = 1'b0;
        smp();
        chk("rst_req_ready", 32'(bus.req_ready_o), 32'h0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'h0);
        chk("rst_rsp_err",   32'(bus.rsp_err_o), 32'h0);
        chk("rst_result",    bus.rsp_result_o, 32'h0);
        chk("rst_busy",      32'(busy), 32'h0);
        chk("rst_grant",     32'(grant_id), 32'h0);
        chk("rst_enable",    32'(mul_enable), 32'h0);
        chk("rst_operand_a", mul_operand_a, 32'h0);

        // Single MUL: 3 * -5 with immediate response accept
        nxt();
        set_req(0, MUL_MAC32, 2'b00, 32'd3, 32'hFFFF_FFFB, 32'd0);
        bus.req_valid_i = 2'b01;
        bus.rsp_ready_i = 2'b11;
        smp();
        chk("single_req_ready", 32'(bus.req_ready_o), 32'h1);
        nxt();
        bus.req_valid_i = 2'b00;
        smp();
        chk("single_busy",    32'(busy), 32'h1);
        chk("single_enable",  32'(mul_enable), 32'h1);
        chk("single_opa",     mul_operand_a, 32'd3);
        chk("single_exready", 32'(mul_ex_ready), 32'h1);
        nxt();
        smp();
        chk("single_rsp_valid", 32'(bus.rsp_valid_o), 32'h1);
        chk("single_result",    bus.rsp_result_o, 32'hFFFF_FFF1);
        chk("single_err",       32'(bus.rsp_err_o), 32'h0);
        nxt();
        smp();
        chk("single_idle", 32'(busy), 32'h0);

        // Reset again so the tie below starts from the reset round-robin pointer
        nxt(); rst = 1'b1;
        nxt(); rst = 1'b0;
        set_req(0, MUL_MAC32, 2'b00, 32'd2, 32'd3, 32'd0);
        set_req(1, MUL_MAC32, 2'b00, 32'd4, 32'd5, 32'd0);
        bus.req_valid_i = 2'b11;
        smp();
        chk("tie_first_ready", 32'(bus.req_ready_o), 32'h1);
        nxt();
        bus.req_valid_i = 2'b10;
        smp();
        chk("tie_first_grant",  32'(grant_id), 32'h0);
        chk("tie_no_ready_busy", 32'(bus.req_ready_o), 32'h0);
        nxt();
        smp();
        chk("tie_first_valid",  32'(bus.rsp_valid_o), 32'h1);
        chk("tie_first_result", bus.rsp_result_o, 32'd6);
        nxt();
        smp();
        chk("tie_second_ready", 32'(bus.req_ready_o), 32'h2);
        nxt();
        bus.req_valid_i = 2'b00;
        smp();
        chk("tie_second_grant", 32'(grant_id), 32'h1);
        nxt();
        smp();
        chk("tie_second_valid",  32'(bus.rsp_valid_o), 32'h2);
        chk("tie_second_result", bus.rsp_result_o, 32'd20);
        nxt();

        // MULH signed 0x80000000^2, then hold the response under backpressure
        bus.rsp_ready_i = 2'b00;
        set_req(1, MUL_H, 2'b11, 32'h8000_0000, 32'h8000_0000, 32'd0);
        bus.req_valid_i = 2'b10;
        exr_base = exr_cnt;
        smp();
        chk("mulh_req_ready", 32'(bus.req_ready_o), 32'h2);
        nxt();
        bus.req_valid_i = 2'b00;
        for (int i = 0; i < 3; i++) begin
            smp();
            chk("mulh_enable",   32'(mul_enable), 32'h1);
            chk("mulh_operator", 32'(mul_operator), 32'(MUL_H));
            chk("mulh_opa",      mul_operand_a, 32'h8000_0000);
            chk("mulh_opb",      mul_operand_b, 32'h8000_0000);
            chk("mulh_wait_exr", 32'(mul_ex_ready), 32'h0);
            chk("mulh_wait_rsp", 32'(bus.rsp_valid_o), 32'h0);
            nxt();
        end
        smp();
        chk("mulh_ready_exr", 32'(mul_ex_ready), 32'h1);
        nxt();
        set_req(0, MUL_MAC32, 2'b00, 32'd7, 32'd7, 32'd0);
        bus.req_valid_i = 2'b01;
        bus.rsp_ready_i = 2'b01;
        stall = 1'b1;
        smp();
        chk("mulh_rsp_valid", 32'(bus.rsp_valid_o), 32'h2);
        chk("mulh_result",    bus.rsp_result_o, 32'h4000_0000);
        chk("mulh_exr_once",  32'(exr_cnt - exr_base), 32'd1);
        for (int i = 0; i < 4; i++) begin
            nxt();
            smp();
            chk("bp_rsp_valid", 32'(bus.rsp_valid_o), 32'h2);
            chk("bp_result",    bus.rsp_result_o, 32'h4000_0000);
            chk("bp_req_ready", 32'(bus.req_ready_o), 32'h0);
            chk("bp_busy",      32'(busy), 32'h1);
        end
        nxt();
        bus.rsp_ready_i = 2'b10;
        nxt();
        bus.rsp_ready_i = 2'b00;

        // Watchdog: pending req0 is granted but the multiplier never becomes ready
        exr_base = exr_cnt;
        smp();
        chk("wd_req_ready", 32'(bus.req_ready_o), 32'h1);
        nxt();
        bus.req_valid_i = 2'b00;
        for (int i = 0; i < 8; i++) begin
            smp();
            chk("wd_busy_enable", 32'(mul_enable), 32'h1);
            chk("wd_busy_rsp",    32'(bus.rsp_valid_o), 32'h0);
            chk("wd_busy_exr",    32'(mul_ex_ready), 32'h0);
            nxt();
        end
        smp();
        chk("wd_rsp_valid", 32'(bus.rsp_valid_o), 32'h1);
        chk("wd_err",       32'(bus.rsp_err_o), 32'h1);
        chk("wd_result",    bus.rsp_result_o, 32'h0);
        chk("wd_flush",     32'(mul_ex_ready), 32'h1);
        chk("wd_enable_lo", 32'(mul_enable), 32'h0);
        nxt();
        smp();
        chk("wd_flush_once", 32'(exr_cnt - exr_base), 32'd1);
        chk("wd_err_hold",   32'(bus.rsp_err_o), 32'h1);
        nxt();
        bus.rsp_ready_i = 2'b01;
        stall = 1'b0;
        nxt();
        bus.rsp_ready_i = 2'b00;

        // Reset during MULH: req1 wins (pointer at 0), then reset drops it
        set_req(1, MUL_H, 2'b11, 32'h8000_0000, 32'h8000_0000, 32'd0);
        bus.req_valid_i = 2'b11;
        smp();
        chk("rm_req_ready", 32'(bus.req_ready_o), 32'h2);
        nxt();
        bus.req_valid_i = 2'b01;
        smp();
        chk("rm_busy", 32'(busy), 32'h1);
        nxt();
        rst = 1'b1;
        smp();
        chk("rm_enable_drop", 32'(mul_enable), 32'h0);
        chk("rm_no_rsp",      32'(bus.rsp_valid_o), 32'h0);
        nxt();
        rst = 1'b0;
        bus.req_valid_i = 2'b11;
        bus.rsp_ready_i = 2'b11;
        smp();
        chk("rm_idle",       32'(busy), 32'h0);
        chk("rm_no_rsp2",    32'(bus.rsp_valid_o), 32'h0);
        chk("rm_tie_req0",   32'(bus.req_ready_o), 32'h1);
        nxt();
        bus.req_valid_i = 2'b00;
        smp();
        chk("rm_grant0", 32'(grant_id), 32'h0);
        nxt(); nxt(); nxt();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
